// File: rtl/tinyriscv_pkg.sv
// tinyriscv_pkg -- shared core constants and the instruction-fetch types.
//
// Contents:
//   InstAddrBus / InstBus / Hold_Flag_Bus : bus widths
//   Hold_Pc                               : hold level that freezes the PC
//   JumpEnable                            : asserted value of a jump/flush
//   CpuResetAddr                          : first fetch address after reset
//   ifu_state_e, IfuFifoDepth, ifu_entry_t: fetch-unit FSM, buffer depth, entry
package tinyriscv_pkg;

  localparam int InstAddrBus   = 32;
  localparam int InstBus       = 32;
  localparam int Hold_Flag_Bus = 3;

  localparam logic [Hold_Flag_Bus-1:0] Hold_Pc = 3'b001;
  localparam logic JumpEnable = 1'b1;
  localparam logic [InstAddrBus-1:0] CpuResetAddr = 32'h0000_0000;

  typedef enum logic [1:0] {
    IFU_IDLE = 2'd0,
    IFU_REQ  = 2'd1,
    IFU_WAIT = 2'd2
  } ifu_state_e;

  localparam int IfuFifoDepth = 2;

  typedef struct packed {
    logic [InstBus-1:0]     inst;
    logic [InstAddrBus-1:0] addr;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo -- small synchronous FIFO of fetched instructions.
//
// Ports:
//   clk, rst (async, active-low)
//   push / wdata : write one entry
//   pop          : drop the head entry
//   flush        : empty the FIFO (wins over push/pop)
//   rdata        : head entry (reset value: inst 0, addr CpuResetAddr)
//   count        : current number of entries
//   empty        : count == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module ifu_fifo
  import tinyriscv_pkg::*;
#(
  parameter int DEPTH = IfuFifoDepth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  ifu_entry_t                 wdata,
  output ifu_entry_t                 rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam ifu_entry_t RESET_ENTRY = '{inst: '0, addr: CpuResetAddr};

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  ifu_entry_t    mem_reg [DEPTH];

  // Storage is reset so the head shows the architectural reset values.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem_reg[gi] <= RESET_ENTRY;
      end else if (push && !flush && (wr_ptr_reg == AW'(gi))) begin
        mem_reg[gi] <= wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  assign rdata = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch -- instruction fetch unit between the PC register and the
// req/gnt/rvalid instruction bus, with a small buffer towards decode.
//
// Ports:
//   clk, rst (async, active-low)
//   pc_i, jump_flag_i, hold_flag_i : PC and pipeline control inputs
//   fetch_stall_o                  : hold the PC (low only on an accepted request)
//   ibus_req_o/addr_o, ibus_gnt_i  : request channel (one outstanding)
//   ibus_rvalid_i/rdata_i          : response channel
//   inst_valid_o/inst_o/inst_addr_o, id_ready_i : decode handshake
//
// Build option: define IFU_BYPASS_EN to present a response arriving at an
// empty buffer to decode in the same cycle (not buffered if taken at once).
module ifu_fetch
  import tinyriscv_pkg::*;
#(
  parameter int FIFO_DEPTH = IfuFifoDepth
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [InstAddrBus-1:0]   pc_i,
  input  logic                     jump_flag_i,
  input  logic [Hold_Flag_Bus-1:0] hold_flag_i,
  output logic                     fetch_stall_o,
  output logic                     ibus_req_o,
  output logic [InstAddrBus-1:0]   ibus_addr_o,
  input  logic                     ibus_gnt_i,
  input  logic                     ibus_rvalid_i,
  input  logic [InstBus-1:0]       ibus_rdata_i,
  output logic                     inst_valid_o,
  output logic [InstBus-1:0]       inst_o,
  output logic [InstAddrBus-1:0]   inst_addr_o,
  input  logic                     id_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [1:0] ST_IDLE = IFU_IDLE;
  localparam logic [1:0] ST_REQ  = IFU_REQ;
  localparam logic [1:0] ST_WAIT = IFU_WAIT;

  logic [1:0]             state_reg, state_next;
  logic                   kill_reg, kill_next;
  logic [InstAddrBus-1:0] tag_reg;

  logic          jump, hold_ok, in_wait, resp_ok, consume, can_issue;
  logic          fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [OW-1:0] occupancy;
  ifu_entry_t    fifo_head, resp_entry;

  assign jump    = (jump_flag_i == JumpEnable);
  assign hold_ok = (hold_flag_i < Hold_Pc);
  assign in_wait = (state_reg == ST_WAIT);

  // Responses outside WAIT (e.g. stale ones after reset) are ignored; a killed
  // response, or one landing in a jump cycle, is discarded.
  assign resp_ok    = in_wait && ibus_rvalid_i && !kill_reg && !jump;
  assign resp_entry = '{inst: ibus_rdata_i, addr: tag_reg};

  // Entries leaving towards decode this cycle count as freed space.
  assign consume   = inst_valid_o && id_ready_i;
  assign occupancy = {1'b0, fifo_count} + OW'(in_wait) - OW'(consume);
  assign can_issue = (occupancy < OW'(FIFO_DEPTH)) && hold_ok && !jump;

  // A jump withdraws an ungranted request in the same cycle.
  assign ibus_req_o    = (state_reg == ST_REQ) && !jump;
  assign ibus_addr_o   = pc_i;
  assign fetch_stall_o = !(ibus_req_o && ibus_gnt_i);

  assign fifo_pop = !fifo_empty && id_ready_i;

`ifdef IFU_BYPASS_EN
  logic bypass;
  assign bypass       = fifo_empty && resp_ok;
  assign inst_valid_o = !fifo_empty || bypass;
  assign inst_o       = bypass ? ibus_rdata_i : fifo_head.inst;
  assign inst_addr_o  = bypass ? tag_reg : fifo_head.addr;
  assign fifo_push    = resp_ok && !(bypass && id_ready_i);
`else
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_head.inst;
  assign inst_addr_o  = fifo_head.addr;
  assign fifo_push    = resp_ok;
`endif

  always_comb begin
    state_next = state_reg;
    kill_next  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (can_issue) state_next = ST_REQ;
      end
      ST_REQ: begin
        if (jump)            state_next = ST_IDLE;
        else if (ibus_gnt_i) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (ibus_rvalid_i) begin
          // A killed response returns to IDLE so the jump target is fetched fresh.
          if (kill_reg || jump) state_next = ST_IDLE;
          else if (can_issue)   state_next = ST_REQ;
          else                  state_next = ST_IDLE;
        end else begin
          kill_next = kill_reg || jump;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      kill_reg  <= 1'b0;
      tag_reg   <= CpuResetAddr;
    end else begin
      state_reg <= state_next;
      kill_reg  <= kill_next;
      if (ibus_req_o && ibus_gnt_i) tag_reg <= pc_i;
    end
  end

  ifu_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (jump),
    .wdata (resp_entry),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule
